// File: rtl/illum_capture_sequencer_pkg.sv
// Shared definitions for the illumination/capture sequencer: FSM encoding,
// phase-table word layout and laser-select bit positions.
package illum_capture_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_DLP    = 3'd2,
    ST_EXPOSE = 3'd3,
    ST_GAP    = 3'd4
  } state_t;

  // Word 0: flags and settle time
  localparam int W0_SEL_LSB    = 0;
  localparam int W0_DLP_BIT    = 2;
  localparam int W0_SETTLE_LSB = 16;
  // Word 1: exposure and gap time
  localparam int W1_EXPOSE_LSB = 0;
  localparam int W1_GAP_LSB    = 16;

  localparam int LASER_BLUE = 0;
  localparam int LASER_RED  = 1;

  typedef struct packed {
    logic [1:0]  sel;
    logic        dlp;
    logic [15:0] settle;
    logic [15:0] expose;
    logic [15:0] gap;
  } phase_cfg_t;

  // Index of the last phase in a loop: 0 behaves as 1, oversize clamps to depth.
  function automatic logic [2:0] last_phase(input logic [2:0] num, input int depth);
    logic [3:0] n;
    n = {1'b0, num};
    if (n == 4'd0) n = 4'd1;
    else if (n > 4'(depth)) n = 4'(depth);
    return 3'(n - 4'd1);
  endfunction

endpackage

// File: rtl/illum_capture_sequencer_if.sv
// Control/status and illumination pin bundle of the sequencer.
interface illum_capture_sequencer_if;
  logic        cfg_wr_i;
  logic [3:0]  cfg_addr_i;
  logic [31:0] cfg_wdata_i;
  logic [2:0]  num_phases_i;
  logic [7:0]  loop_count_i;
  logic        start_i;
  logic        abort_i;
  logic        busy_o;
  logic        done_o;
  logic [2:0]  phase_o;
  logic [15:0] frame_cnt_o;
  logic        b_laser_en_o;
  logic        r_laser_en_o;
  logic        dlp_en_o;
  logic        xtrig_o;

  modport master (
    output cfg_wr_i, cfg_addr_i, cfg_wdata_i, num_phases_i, loop_count_i, start_i, abort_i,
    input  busy_o, done_o, phase_o, frame_cnt_o, b_laser_en_o, r_laser_en_o, dlp_en_o, xtrig_o
  );

  modport slave (
    input  cfg_wr_i, cfg_addr_i, cfg_wdata_i, num_phases_i, loop_count_i, start_i, abort_i,
    output busy_o, done_o, phase_o, frame_cnt_o, b_laser_en_o, r_laser_en_o, dlp_en_o, xtrig_o
  );
endinterface

// File: rtl/illum_capture_sequencer_us_tick_gen.sv
// Microsecond prescaler: down-counter that pulses tick_o for one cycle every
// CLK_PER_US cycles; clr_i restarts the period so the first tick lands
// CLK_PER_US cycles after the clear.
module illum_capture_sequencer_us_tick_gen #(
  parameter int CLK_PER_US = 50
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);
  localparam int CW = $clog2(CLK_PER_US);
  localparam logic [CW-1:0] RELOAD = CW'(CLK_PER_US - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Reload on clear or terminal count, otherwise count down
  always_comb begin
    cnt_d = cnt_q - 1'b1;
    if (clr_i || (cnt_q == '0)) cnt_d = RELOAD;
  end

  // Prescaler register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= RELOAD;
    else       cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == '0);
endmodule

// File: rtl/illum_capture_sequencer.sv
// Illumination/capture sequencer. Walks a programmable phase table; each
// phase runs SETTLE, optional DLP pulse, EXPOSE and GAP with microsecond
// durations. All outputs are registered from the next-state values.
//
//  state  | meaning
//  IDLE   | waiting for start, all pins low
//  SETTLE | lasers on per sel, waiting settle_us
//  DLP    | lasers on, DLP pulse high for DLP_PULSE_US
//  EXPOSE | lasers on, camera XTRIG high for expose_us
//  GAP    | all pins low for gap_us, then next phase or end of loop
module illum_capture_sequencer
  import illum_capture_sequencer_pkg::*;
#(
  parameter int CLK_PER_US   = 50,
  parameter int NUM_PHASES   = 4,
  parameter int DLP_PULSE_US = 200
) (
  input logic                       ctrl_clk_i,
  input logic                       ctrl_rst_i,
  illum_capture_sequencer_if.slave  bus
);
  localparam int PW = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
  localparam logic [15:0] DLP_US = 16'(DLP_PULSE_US);

  phase_cfg_t  tbl_q [NUM_PHASES];
  phase_cfg_t  shadow_q, shadow_d;
  state_t      state_q, state_d;
  logic [2:0]  phase_q, phase_d, last_q, last_d, phase_nxt, wr_phase;
  logic [7:0]  loops_q, loops_d, loop_cnt_q, loop_cnt_d, loop_inc;
  logic [15:0] frame_q, frame_d, us_q, us_d, dur;
  logic        busy_q, busy_d, done_q, done_d;
  logic        b_q, b_d, r_q, r_d, dlp_q, dlp_d, xtrig_q, xtrig_d;
  logic        tick, clr, dur_end, lit;

  assign wr_phase = bus.cfg_addr_i[3:1];

  // Phase table: writes land any time, running phases pick them up on their next entry
  always_ff @(posedge ctrl_clk_i or posedge ctrl_rst_i) begin
    if (ctrl_rst_i) begin
      for (int i = 0; i < NUM_PHASES; i++) tbl_q[i] <= '0;
    end else if (bus.cfg_wr_i && ({1'b0, wr_phase} < 4'(NUM_PHASES))) begin
      if (bus.cfg_addr_i[0]) begin
        tbl_q[wr_phase[PW-1:0]].expose <= bus.cfg_wdata_i[W1_EXPOSE_LSB +: 16];
        tbl_q[wr_phase[PW-1:0]].gap    <= bus.cfg_wdata_i[W1_GAP_LSB +: 16];
      end else begin
        tbl_q[wr_phase[PW-1:0]].sel    <= bus.cfg_wdata_i[W0_SEL_LSB +: 2];
        tbl_q[wr_phase[PW-1:0]].dlp    <= bus.cfg_wdata_i[W0_DLP_BIT];
        tbl_q[wr_phase[PW-1:0]].settle <= bus.cfg_wdata_i[W0_SETTLE_LSB +: 16];
      end
    end
  end

  illum_capture_sequencer_us_tick_gen #(.CLK_PER_US(CLK_PER_US)) u_tick (
    .clk_i  (ctrl_clk_i),
    .rst_i  (ctrl_rst_i),
    .clr_i  (clr),
    .tick_o (tick)
  );

  // Duration of the current state and its terminal-count detect
  always_comb begin
    dur = '0;
    case (state_q)
      ST_SETTLE: dur = shadow_q.settle;
      ST_DLP:    dur = DLP_US;
      ST_EXPOSE: dur = shadow_q.expose;
      ST_GAP:    dur = shadow_q.gap;
      default:   dur = '0;
    endcase
    dur_end = (dur == '0) || (tick && (us_q == dur - 16'd1));
  end

  // Next-state logic: sequencing, phase/loop bookkeeping and shadow latch
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    shadow_d   = shadow_q;
    frame_d    = frame_q;
    last_d     = last_q;
    loops_d    = loops_q;
    loop_cnt_d = loop_cnt_q;
    done_d     = 1'b0;
    phase_nxt  = phase_q + 3'd1;
    loop_inc   = loop_cnt_q + 8'd1;
    if (state_q == ST_IDLE) begin
      if (bus.start_i && !bus.abort_i) begin
        state_d    = ST_SETTLE;
        phase_d    = '0;
        shadow_d   = tbl_q[0];
        frame_d    = '0;
        loop_cnt_d = '0;
        last_d     = last_phase(bus.num_phases_i, NUM_PHASES);
        loops_d    = bus.loop_count_i;
      end
    end else if (bus.abort_i) begin
      state_d = ST_IDLE;
    end else if (dur_end) begin
      case (state_q)
        ST_SETTLE: begin
          state_d = shadow_q.dlp ? ST_DLP : ST_EXPOSE;
          if (!shadow_q.dlp) frame_d = frame_q + 16'd1;
        end
        ST_DLP: begin
          state_d = ST_EXPOSE;
          frame_d = frame_q + 16'd1;
        end
        ST_EXPOSE: state_d = ST_GAP;
        ST_GAP: begin
          if (phase_q == last_q) begin
            loop_cnt_d = loop_inc;
            if ((loops_q != 8'd0) && (loop_inc == loops_q)) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d  = ST_SETTLE;
              phase_d  = '0;
              shadow_d = tbl_q[0];
            end
          end else begin
            state_d  = ST_SETTLE;
            phase_d  = phase_nxt;
            shadow_d = tbl_q[phase_nxt[PW-1:0]];
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Pin values for the state being entered, plus microsecond counter update
  always_comb begin
    lit     = (state_d == ST_SETTLE) || (state_d == ST_DLP) || (state_d == ST_EXPOSE);
    b_d     = lit && shadow_d.sel[LASER_BLUE];
    r_d     = lit && shadow_d.sel[LASER_RED];
    dlp_d   = (state_d == ST_DLP);
    xtrig_d = (state_d == ST_EXPOSE);
    busy_d  = (state_d != ST_IDLE);
    clr     = (state_q == ST_IDLE) || (state_d != state_q);
    us_d    = us_q;
    if (clr)       us_d = '0;
    else if (tick) us_d = us_q + 16'd1;
  end

  // State and output registers
  always_ff @(posedge ctrl_clk_i or posedge ctrl_rst_i) begin
    if (ctrl_rst_i) begin
      state_q    <= ST_IDLE;
      shadow_q   <= '0;
      phase_q    <= '0;
      last_q     <= '0;
      loops_q    <= '0;
      loop_cnt_q <= '0;
      frame_q    <= '0;
      us_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      b_q        <= 1'b0;
      r_q        <= 1'b0;
      dlp_q      <= 1'b0;
      xtrig_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      phase_q    <= phase_d;
      last_q     <= last_d;
      loops_q    <= loops_d;
      loop_cnt_q <= loop_cnt_d;
      frame_q    <= frame_d;
      us_q       <= us_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      b_q        <= b_d;
      r_q        <= r_d;
      dlp_q      <= dlp_d;
      xtrig_q    <= xtrig_d;
    end
  end

  assign bus.busy_o       = busy_q;
  assign bus.done_o       = done_q;
  assign bus.phase_o      = phase_q;
  assign bus.frame_cnt_o  = frame_q;
  assign bus.b_laser_en_o = b_q;
  assign bus.r_laser_en_o = r_q;
  assign bus.dlp_en_o     = dlp_q;
  assign bus.xtrig_o      = xtrig_q;
endmodule

// File: tb/tb_illum_capture_sequencer.sv
// Bench for illum_capture_sequencer with CLK_PER_US=4, DLP_PULSE_US=2.
module tb_illum_capture_sequencer;
  localparam int CPU = 4;

  logic clk, rst;
  illum_capture_sequencer_if bus();

  illum_capture_sequencer #(.CLK_PER_US(CPU), .NUM_PHASES(4), .DLP_PULSE_US(2)) dut (
    .ctrl_clk_i (clk),
    .ctrl_rst_i (rst),
    .bus        (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  typedef struct packed {
    logic [3:0][31:0] w0;
    logic [3:0][31:0] w1;
    int np, loops, busy, blue, red, dlp, x, dfirst, frames;
  } vec_t;

  typedef struct {
    int phase, frame, len;
    bit b, r;
  } exp_t;

  typedef struct {
    int busy, blue, red, dlp, x, dfirst, done, frame;
  } res_t;

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb_q[$];
  vec_t vecs[5];

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [31:0] a0, a1, a2, a3, b0, b1, b2, b3,
                               input int np, loops, busy, blue, red, dlp, x, dfirst, frames);
    vec_t v;
    v.w0[0] = a0; v.w0[1] = a1; v.w0[2] = a2; v.w0[3] = a3;
    v.w1[0] = b0; v.w1[1] = b1; v.w1[2] = b2; v.w1[3] = b3;
    v.np = np; v.loops = loops; v.busy = busy; v.blue = blue; v.red = red;
    v.dlp = dlp; v.x = x; v.dfirst = dfirst; v.frames = frames;
    return v;
  endfunction

  task automatic cfg_write(input logic [3:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.cfg_wr_i = 1'b1; bus.cfg_addr_i = addr; bus.cfg_wdata_i = data;
    @(negedge clk);
    bus.cfg_wr_i = 1'b0;
  endtask

  task automatic prog(input vec_t v);
    for (int p = 0; p < 4; p++) begin
      cfg_write(4'(2 * p), v.w0[p]);
      cfg_write(4'(2 * p + 1), v.w1[p]);
    end
    bus.num_phases_i = 3'(v.np);
    bus.loop_count_i = 8'(v.loops);
  endtask

  // Expected exposures of a run: one entry per EXPOSE entry in order
  task automatic push_vec(input vec_t v);
    int eff, fr;
    logic [31:0] w0, w1;
    exp_t e;
    eff = (v.np == 0) ? 1 : ((v.np > 4) ? 4 : v.np);
    fr = 0;
    for (int l = 0; l < v.loops; l++)
      for (int p = 0; p < eff; p++) begin
        w0 = v.w0[p]; w1 = v.w1[p];
        fr++;
        e.phase = p; e.frame = fr;
        e.len = (w1[15:0] == 16'd0) ? 1 : int'(w1[15:0]) * CPU;
        e.b = w0[0]; e.r = w0[1];
        sb_q.push_back(e);
      end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
  endtask

  // Start a run and monitor it to completion; optional mid-run table writes
  task automatic run_seq(input int budget, input bit do_wr, output res_t r);
    bit   prev_x, fin;
    int   len, c;
    exp_t cur;
    r = '{default: 0};
    prev_x = 1'b0; fin = 1'b0; len = 0;
    cur = '{default: 0};
    pulse_start();
    chk("start_busy", bus.busy_o, 1);
    chk("start_phase", bus.phase_o, 0);
    chk("start_frame", bus.frame_cnt_o, 0);
    for (c = 1; c <= budget && !fin; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (do_wr) begin
        bus.cfg_wr_i = (c <= 2);
        bus.cfg_addr_i = (c == 1) ? 4'd3 : 4'd1;
        bus.cfg_wdata_i = (c == 1) ? 32'h0000_0005 : 32'h0001_0007;
      end
      if (bus.busy_o) r.busy++;
      if (bus.b_laser_en_o) r.blue++;
      if (bus.r_laser_en_o) r.red++;
      if (bus.dlp_en_o) begin
        r.dlp++;
        if (r.dfirst == 0) r.dfirst = c;
      end
      if (bus.xtrig_o) r.x++;
      if (bus.xtrig_o && !prev_x) begin
        chk("sb_has_entry", sb_q.size() > 0, 1);
        if (sb_q.size() > 0) begin
          cur = sb_q.pop_front();
          chk("exp_phase", bus.phase_o, cur.phase);
          chk("exp_frame", bus.frame_cnt_o, cur.frame);
          chk("exp_blue", bus.b_laser_en_o, cur.b);
          chk("exp_red", bus.r_laser_en_o, cur.r);
        end
        len = 0;
      end
      if (bus.xtrig_o) len++;
      if (!bus.xtrig_o && prev_x) chk("xtrig_len", len, cur.len);
      prev_x = bus.xtrig_o;
      if (bus.done_o) begin
        r.done++;
        r.frame = bus.frame_cnt_o;
        fin = 1'b1;
      end
    end
    bus.cfg_wr_i = 1'b0;
    chk("run_finished", fin, 1);
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.done_o) r.done++;
    end
    chk("idle_after_run", bus.busy_o, 0);
  endtask

  task automatic check_vec(input vec_t v, input res_t r);
    chk("busy_cycles", r.busy, v.busy);
    chk("blue_cycles", r.blue, v.blue);
    chk("red_cycles", r.red, v.red);
    chk("dlp_cycles", r.dlp, v.dlp);
    chk("xtrig_cycles", r.x, v.x);
    chk("dlp_first_cycle", r.dfirst, v.dfirst);
    chk("done_pulses", r.done, 1);
    chk("final_frame", r.frame, v.frames);
    chk("sb_drained", sb_q.size(), 0);
  endtask

  function automatic int pins();
    return int'({bus.b_laser_en_o, bus.r_laser_en_o, bus.dlp_en_o, bus.xtrig_o, bus.busy_o, bus.done_o});
  endfunction

  initial begin
    res_t r;
    int   rises, dones;
    bit   prev;
    exp_t e;

    bus.cfg_wr_i = 0; bus.cfg_addr_i = 0; bus.cfg_wdata_i = 0;
    bus.num_phases_i = 0; bus.loop_count_i = 0; bus.start_i = 0; bus.abort_i = 0;
    rst = 1'b1;

    //        w0[0..3]                                    w1[0..3]                                       np lp busy blu red dlp  x df fr
    vecs[0] = mkv(32'h0002_0005, 0, 0, 0,                 32'h0001_0003, 0, 0, 0,                        1, 1, 32, 28,  0,  8, 12, 9, 1);
    vecs[1] = mkv(32'h0001_0001, 32'h6, 32'h0002_0003, 0, 32'h0001_0002, 32'h1, 32'h0002_0000, 0,         3, 2, 94, 42, 44, 16, 26,18, 6);
    vecs[2] = mkv(32'h1, 32'h2, 0, 0,                     0, 0, 0, 0,                                    2, 1,  6,  2,  2,  0,  2, 0, 2);
    vecs[3] = mkv(32'h1, 32'h2, 0, 0,                     0, 0, 0, 0,                                    0, 1,  3,  2,  0,  0,  1, 0, 1);
    vecs[4] = mkv(32'h1, 32'h2, 32'h3, 0,                 0, 0, 0, 0,                                    7, 1, 12,  4,  4,  0,  4, 0, 4);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_pins", pins(), 0);
    chk("reset_frame", bus.frame_cnt_o, 0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven runs
    for (int i = 0; i < 5; i++) begin
      prog(vecs[i]);
      push_vec(vecs[i]);
      run_seq(400, 1'b0, r);
      check_vec(vecs[i], r);
    end

    // Table writes during phase 0 of a 2-phase, 2-loop run
    prog(mkv(32'h1, 32'h2, 0, 0, 32'h0001_0002, 32'h1, 0, 0, 2, 2, 0, 0, 0, 0, 0, 0, 0));
    e.b = 1; e.r = 0; e.phase = 0; e.frame = 1; e.len = 8;  sb_q.push_back(e);
    e.b = 0; e.r = 1; e.phase = 1; e.frame = 2; e.len = 20; sb_q.push_back(e);
    e.b = 1; e.r = 0; e.phase = 0; e.frame = 3; e.len = 28; sb_q.push_back(e);
    e.b = 0; e.r = 1; e.phase = 1; e.frame = 4; e.len = 20; sb_q.push_back(e);
    run_seq(400, 1'b1, r);
    chk("midwr_done", r.done, 1);
    chk("midwr_frames", r.frame, 4);
    chk("midwr_sb_drained", sb_q.size(), 0);

    // Abort mid-EXPOSE, then a normal restart
    prog(vecs[0]);
    pulse_start();
    for (int i = 0; i < 100 && !bus.xtrig_o; i++) begin @(posedge clk); #1; end
    chk("abort_reached_expose", bus.xtrig_o, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.abort_i = 1'b1;
    @(posedge clk); #1;
    bus.abort_i = 1'b0;
    chk("abort_pins", pins(), 0);
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done_o || bus.busy_o) dones++;
    end
    chk("abort_quiet", dones, 0);
    push_vec(vecs[0]);
    run_seq(400, 1'b0, r);
    check_vec(vecs[0], r);

    // Endless run: 10 loops of 2 phases then abort
    prog(vecs[2]);
    bus.loop_count_i = 8'd0;
    pulse_start();
    rises = 0; dones = 0; prev = 0;
    for (int i = 0; i < 300 && rises < 20; i++) begin
      @(posedge clk); #1;
      if (bus.done_o) dones++;
      if (bus.xtrig_o && !prev) rises++;
      prev = bus.xtrig_o;
    end
    chk("free_run_frames", bus.frame_cnt_o, 20);
    chk("free_run_busy", bus.busy_o, 1);
    @(negedge clk);
    bus.abort_i = 1'b1;
    @(posedge clk); #1;
    bus.abort_i = 1'b0;
    chk("free_run_abort", pins(), 0);
    chk("free_run_no_done", dones, 0);

    // start and abort together: stays idle
    @(negedge clk);
    bus.start_i = 1'b1; bus.abort_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0; bus.abort_i = 1'b0;
    dones = 0;
    repeat (4) begin
      if (bus.busy_o || bus.b_laser_en_o) dones++;
      @(posedge clk); #1;
    end
    chk("start_abort_idle", dones, 0);

    // Asynchronous reset in the middle of a DLP pulse
    prog(vecs[0]);
    pulse_start();
    for (int i = 0; i < 100 && !bus.dlp_en_o; i++) begin @(posedge clk); #1; end
    chk("reset_reached_dlp", bus.dlp_en_o, 1);
    #1 rst = 1'b1;
    #1;
    chk("async_reset_pins", pins(), 0);
    chk("async_reset_phase", bus.phase_o, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("after_reset_idle", bus.busy_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
